// File: rtl/reflejos_pkg.sv
// Shared types and constants for the reflex-game sequencer.
// FSM encoding, LFSR seed, feedback LED patterns and small helpers.
package reflejos_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT,
      SHOW,
      HIT,
      MISS,
      FB,
      DONE
   } state_t;

   localparam int          NUM_BTN   = 4;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [3:0]  FB_HIT    = 4'b1111;
   localparam logic [3:0]  FB_MISS   = 4'b1001;
   localparam logic [9:0]  NO_TIME   = 10'd1023;

   function automatic logic [3:0] led_onehot(input logic [1:0] t);
      return 4'b0001 << t;
   endfunction

   // The ms counter is 11 bits; anything past 1023 reports as NO_TIME.
   function automatic logic [9:0] sat_ms(input logic [10:0] c);
      return c[10] ? NO_TIME : c[9:0];
   endfunction

endpackage

// File: rtl/reflejos_btn_sync.sv
// Button synchronizer: 2-FF sync plus registered copy, one-cycle press pulse on high-to-low.
// Latency 3 cycles from pin to the FSM acting on the edge; no backpressure.
module reflejos_btn_sync
   import reflejos_pkg::*;
(
   input  logic               Clock,
   input  logic               Reset,
   input  logic [NUM_BTN-1:0] btn,
   output logic [NUM_BTN-1:0] press_edge
);

   logic [NUM_BTN-1:0] meta;
   logic [NUM_BTN-1:0] sync;
   logic [NUM_BTN-1:0] sync_q;

   // Reset to the released level so a held button at reset never fires.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         meta   <= '1;
         sync   <= '1;
         sync_q <= '1;
      end else begin
         meta   <= btn;
         sync   <= meta;
         sync_q <= sync;
      end
   end

   assign press_edge = ~sync & sync_q;

endmodule

// File: rtl/reflejos_ctrl.sv
// Reflex-game sequencer: LFSR-driven random delay and target, ms reaction timing, scoring.
// Outputs registered; button presses act 3 cycles after the pin; no backpressure.
module reflejos_ctrl #(
   parameter int TICK_DIV     = 27000,
   parameter int ROUNDS       = 8,
   parameter int MIN_DELAY_MS = 500,
   parameter int TIMEOUT_MS   = 1000,
   parameter int FB_MS        = 200
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       start,
   input  logic [3:0] BTN,
   output logic [3:0] LED,
   output logic [3:0] score,
   output logic [3:0] round_idx,
   output logic [9:0] reaction_ms,
   output logic [9:0] best_ms,
   output logic       busy,
   output logic       game_over
);
   import reflejos_pkg::*;

   localparam int          TW        = $clog2(TICK_DIV + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [10:0] MIN_C     = 11'(MIN_DELAY_MS);
   localparam logic [10:0] TIMEOUT_C = 11'(TIMEOUT_MS);
   localparam logic [10:0] FB_LAST   = 11'(FB_MS - 1);
   localparam logic [3:0]  ROUNDS_C  = 4'(ROUNDS);

   state_t          state;
   logic [15:0]     lfsr;
   logic            lfsr_fb;
   logic [TW-1:0]   tick_cnt;
   logic            tick;
   logic [10:0]     ms_cnt;
   logic [10:0]     delay_ms;
   logic [1:0]      target;
   logic [3:0]      press_edge;
   logic            any_edge;
   logic            wrong_edge;

   reflejos_btn_sync u_btn_sync (
      .Clock      (Clock),
      .Reset      (Reset),
      .btn        (BTN),
      .press_edge (press_edge)
   );

   assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign tick       = (tick_cnt == TICK_LAST);
   assign any_edge   = |press_edge;
   assign wrong_edge = |(press_edge & ~led_onehot(target));

   // Every transition also zeroes tick_cnt so the first tick in a state
   // lands exactly TICK_DIV cycles after entry.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state       <= IDLE;
         LED         <= '0;
         score       <= '0;
         round_idx   <= '0;
         reaction_ms <= '0;
         best_ms     <= NO_TIME;
         busy        <= 1'b0;
         game_over   <= 1'b0;
         lfsr        <= LFSR_SEED;
         tick_cnt    <= '0;
         ms_cnt      <= '0;
         delay_ms    <= '0;
         target      <= '0;
      end else begin
         lfsr     <= {lfsr[14:0], lfsr_fb};
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         if (tick && ms_cnt != '1)
            ms_cnt <= ms_cnt + 1'b1;

         case (state)
            IDLE: begin
               LED <= '0;
               if (start) begin
                  state    <= LOAD;
                  busy     <= 1'b1;
                  tick_cnt <= '0;
               end
            end

            LOAD: begin
               delay_ms <= MIN_C + {1'b0, lfsr[9:0]};
               target   <= lfsr[11:10];
               ms_cnt   <= '0;
               LED      <= '0;
               state    <= WAIT;
               tick_cnt <= '0;
            end

            WAIT: begin
               // A press coinciding with delay expiry still counts as a false start.
               if (any_edge) begin
                  state    <= MISS;
                  tick_cnt <= '0;
               end else if (ms_cnt == delay_ms) begin
                  LED      <= led_onehot(target);
                  ms_cnt   <= '0;
                  state    <= SHOW;
                  tick_cnt <= '0;
               end
            end

            SHOW: begin
               if (any_edge) begin
                  reaction_ms <= sat_ms(ms_cnt);
                  state       <= wrong_edge ? MISS : HIT;
                  tick_cnt    <= '0;
               end else if (ms_cnt == TIMEOUT_C) begin
                  reaction_ms <= NO_TIME;
                  state       <= MISS;
                  tick_cnt    <= '0;
               end
            end

            HIT: begin
               if (score != ROUNDS_C)
                  score <= score + 1'b1;
               if (reaction_ms < best_ms)
                  best_ms <= reaction_ms;
               LED      <= FB_HIT;
               ms_cnt   <= '0;
               state    <= FB;
               tick_cnt <= '0;
            end

            MISS: begin
               LED      <= FB_MISS;
               ms_cnt   <= '0;
               state    <= FB;
               tick_cnt <= '0;
            end

            FB: begin
               if (tick && ms_cnt == FB_LAST) begin
                  round_idx <= round_idx + 1'b1;
                  tick_cnt  <= '0;
                  if (round_idx + 4'd1 == ROUNDS_C) begin
                     LED       <= score;
                     busy      <= 1'b0;
                     game_over <= 1'b1;
                     state     <= DONE;
                  end else begin
                     LED   <= '0;
                     state <= LOAD;
                  end
               end
            end

            DONE: begin
               LED <= score;
               if (start) begin
                  score       <= '0;
                  round_idx   <= '0;
                  best_ms     <= NO_TIME;
                  reaction_ms <= '0;
                  LED         <= '0;
                  busy        <= 1'b1;
                  game_over   <= 1'b0;
                  state       <= LOAD;
                  tick_cnt    <= '0;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
